// File: rtl/mux2_rr_arbiter.sv
// Round-robin grant sequencer for a shared 2:1 valid/ready mux; grants are held for a whole packet.
// Optional MUX2_ARB_BURST_LIMIT_EN caps each grant at MAX_BURST beats.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic [1:0]       grant
);

  // State encoding doubles as the one-hot grant.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t state, state_next;
  logic   prio, prio_next;
  logic   sel_next;
  logic   xfer;
  logic   release_now;

  assign grant = state;

  always_comb begin
    out_data  = sel ? in1_data : in0_data;
    out_last  = sel ? in1_last : in0_last;
    out_valid = 1'b0;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    case (state)
      G0: begin
        out_valid = in0_valid;
        in0_ready = out_ready;
      end
      G1: begin
        out_valid = in1_valid;
        in1_ready = out_ready;
      end
      default: ;
    endcase
  end

  assign xfer = out_valid && out_ready;

`ifdef MUX2_ARB_BURST_LIMIT_EN
  logic [7:0] beats;
  logic       burst_hit;

  // The transfer that brings beats up to MAX_BURST ends the grant.
  assign burst_hit   = (beats == 8'(MAX_BURST - 1));
  assign release_now = xfer && (out_last || burst_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats <= 8'd0;
    end else if (release_now) begin
      beats <= 8'd0;
    end else if (xfer && (beats != 8'(MAX_BURST))) begin
      beats <= beats + 8'd1;
    end
  end
`else
  assign release_now = xfer && out_last;
`endif

  always_comb begin
    state_next = state;
    prio_next  = prio;
    case (state)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          state_next = prio ? G1 : G0;
        end else if (in0_valid) begin
          state_next = G0;
        end else if (in1_valid) begin
          state_next = G1;
        end
      end
      G0: begin
        if (release_now) begin
          prio_next  = 1'b1;
          state_next = in1_valid ? G1 : IDLE;
        end
      end
      G1: begin
        if (release_now) begin
          prio_next  = 1'b0;
          state_next = in0_valid ? G0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // sel keeps its last granted value while idle.
    sel_next = sel;
    if (state_next == G0) begin
      sel_next = 1'b0;
    end else if (state_next == G1) begin
      sel_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
      sel   <= 1'b0;
    end else begin
      state <= state_next;
      prio  <= prio_next;
      sel   <= sel_next;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed packet scenarios plus random traffic against a
// packet-level reference model of the round-robin grant rules.
module tb_mux2_rr_arbiter;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;
`ifdef MUX2_ARB_BURST_LIMIT_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in0_valid, in1_valid, in0_last, in1_last;
  logic [WIDTH-1:0] in0_data, in1_data;
  logic             in0_ready, in1_ready;
  logic             out_valid, out_last, out_ready, sel;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       grant;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .grant(grant)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      src0[$];
  beat_t      src1[$];
  logic [8:0] got[$];
  logic [8:0] exp_q[$];

  int   n_assert = 0;
  int   n_fail   = 0;
  int   m_owner;
  int   m_prio;
  int   m_cnt;
  logic m_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_prio  = 0;
    m_cnt   = 0;
    m_sel   = 1'b0;
  endtask

  task automatic push_pkt(input int src, input int base, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = 8'(base + i);
      b.last = (i == len - 1);
      if (src == 0) src0.push_back(b);
      else          src1.push_back(b);
    end
  endtask

  task automatic drive_heads(input bit g0, input bit g1);
    in0_valid = (src0.size() != 0) && g0;
    in1_valid = (src1.size() != 0) && g1;
    if (src0.size() != 0) begin
      in0_data = src0[0].data; in0_last = src0[0].last;
    end else begin
      in0_data = 8'($urandom); in0_last = 1'b0;
    end
    if (src1.size() != 0) begin
      in1_data = src1[0].data; in1_last = src1[0].last;
    end else begin
      in1_data = 8'($urandom); in1_last = 1'b0;
    end
  endtask

  // One clock: drive, check outputs mid-cycle against the model, then advance the model.
  task automatic step(input bit rnd);
    bit         g0 = 1'b1;
    bit         g1 = 1'b1;
    logic [1:0] eg;
    logic       ev, er0, er1, el;
    logic [7:0] ed;
    int         other;
    if (rnd) begin
      g0 = ($urandom_range(0, 3) != 0);
      g1 = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    drive_heads(g0, g1);
    @(negedge clk);
    eg  = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    ev  = (m_owner == 0) ? in0_valid : ((m_owner == 1) ? in1_valid : 1'b0);
    er0 = (m_owner == 0) && out_ready;
    er1 = (m_owner == 1) && out_ready;
    ed  = m_sel ? in1_data : in0_data;
    el  = m_sel ? in1_last : in0_last;
    chk("grant", grant, eg);
    chk("sel", sel, m_sel);
    chk("out_valid", out_valid, ev);
    chk("in0_ready", in0_ready, er0);
    chk("in1_ready", in1_ready, er1);
    chk("out_data", out_data, ed);
    chk("out_last", out_last, el);
    if (ev && out_ready) begin
      got.push_back({m_owner[0], ed});
      if (m_owner == 0) src0.delete(0);
      else              src1.delete(0);
    end
    @(posedge clk);
    if (m_owner < 0) begin
      if (in0_valid && in1_valid) m_owner = m_prio;
      else if (in0_valid)         m_owner = 0;
      else if (in1_valid)         m_owner = 1;
    end else if (ev && out_ready) begin
      m_cnt++;
      if (el || (BURST && m_cnt == MAX_BURST)) begin
        other   = 1 - m_owner;
        m_prio  = other;
        m_cnt   = 0;
        m_owner = ((other == 0) ? in0_valid : in1_valid) ? other : -1;
      end
    end
    if (m_owner >= 0) m_sel = m_owner[0];
    #1;
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while ((src0.size() != 0 || src1.size() != 0 || m_owner >= 0) && n < budget) begin
      step(1'b0);
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk(tag, got[i], exp_q[i]);
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int   n;
    logic [7:0] held;

    // Reset held with both requesters valid
    model_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    push_pkt(0, 'h01, 1);
    push_pkt(1, 'h02, 1);
    drive_heads(1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_sel", sel, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in0_ready", in0_ready, 1'b0);
    chk("rst_in1_ready", in1_ready, 1'b0);
    chk("rst_out_data", out_data, 8'h01);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0);
    chk("grant_after_reset", grant, 2'b01);
    drain(50, n);
    exp_q = '{9'h001, 9'h102};
    chk_seq("reset_tie");

    // Single requester, 3-beat packet
    push_pkt(1, 'hA1, 3);
    drain(50, n);
    exp_q = '{9'h1A1, 9'h1A2, 9'h1A3};
    chk_seq("single");
    chk("single_back_idle", grant, 2'b00);

    // Contention: strict alternation, no idle cycles
    push_pkt(0, 'h10, 2); push_pkt(0, 'h12, 2);
    push_pkt(1, 'h20, 2); push_pkt(1, 'h22, 2);
    drain(50, n);
    chk("contention_cycles", n, 9);
    exp_q = '{9'h010, 9'h011, 9'h120, 9'h121, 9'h012, 9'h013, 9'h122, 9'h123};
    chk_seq("contention");

    // Backpressure mid-packet
    push_pkt(0, 'h60, 4);
    step(1'b0);
    step(1'b0);
    out_ready = 1'b0;
    held = 8'h61;
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      chk("bp_grant", grant, 2'b01);
      chk("bp_data_stable", out_data, held);
      chk("bp_in0_ready", in0_ready, 1'b0);
    end
    out_ready = 1'b1;
    drain(50, n);
    exp_q = '{9'h060, 9'h061, 9'h062, 9'h063};
    chk_seq("backpressure");

    // Long in0 packet while in1 becomes valid
    push_pkt(0, 'h30, 6);
    step(1'b0);
    push_pkt(1, 'h40, 2);
    drain(50, n);
    if (BURST) exp_q = '{9'h030, 9'h031, 9'h032, 9'h033, 9'h140, 9'h141, 9'h034, 9'h035};
    else       exp_q = '{9'h030, 9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h140, 9'h141};
    chk_seq("burst");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if (src0.size() < 3 && $urandom_range(0, 3) == 0)
        push_pkt(0, int'($urandom_range(0, 255)), int'($urandom_range(1, 6)));
      if (src1.size() < 3 && $urandom_range(0, 3) == 0)
        push_pkt(1, int'($urandom_range(0, 255)), int'($urandom_range(1, 6)));
      step(1'b1);
    end
    out_ready = 1'b1;
    drain(300, n);
    got.delete();

    // Asynchronous reset in the middle of a G1 packet
    push_pkt(1, 'h51, 3);
    step(1'b0);
    step(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", grant, 2'b00);
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_in1_ready", in1_ready, 1'b0);
    chk("async_sel", sel, 1'b0);
    src0.delete(); src1.delete(); got.delete();
    model_reset();
    push_pkt(0, 'h71, 1);
    push_pkt(1, 'h72, 1);
    drive_heads(1'b1, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0);
    chk("grant_after_async", grant, 2'b01);
    drain(50, n);
    exp_q = '{9'h071, 9'h172};
    chk_seq("after_async");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
